// File: rtl/iob_axi_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_axi_read_responder_pkg
// Description : Shared encodings for the AXI4 read responder: burst types,
//               read response codes, FSM state encodings and the burst
//               legality check applied when a request is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_axi_read_responder_pkg;

    // AXI burst encodings
    localparam logic [1:0] c_burst_fixed = 2'b00;
    localparam logic [1:0] c_burst_incr  = 2'b01;
    localparam logic [1:0] c_burst_wrap  = 2'b10;
    localparam logic [1:0] c_burst_rsvd  = 2'b11;

    // AXI read response codes
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    // Responder FSM states
    localparam logic [1:0] c_state_idle  = 2'd0;
    localparam logic [1:0] c_state_issue = 2'd1;
    localparam logic [1:0] c_state_drain = 2'd2;

    // A burst is unserviceable when its beat is wider than the data bus or
    // when it asks for WRAP / the reserved encoding; every beat then errors.
    function automatic logic burst_is_bad(input logic [2:0] size,
                                          input logic [1:0] burst,
                                          input int         nbytes_w);
        return (int'(size) > nbytes_w) ||
               (burst == c_burst_wrap) || (burst == c_burst_rsvd);
    endfunction

    // Only INCR advances the address; FIXED holds it.
    function automatic logic burst_advances(input logic [1:0] burst);
        return (burst == c_burst_incr) && (burst != c_burst_fixed);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_axi_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iob_axi_rd_skid_fifo
// Description : Two-entry FIFO holding R-channel beats {rdata, rresp, rlast}.
//               Head entry is presented combinationally on data_o.
// Ports       : clk_i, reset_i (async, active-high)
//               push_i/data_i  - write one entry
//               pop_i          - retire the head entry
//               data_o         - head entry
//               count_o        - number of valid entries (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module iob_axi_rd_skid_fifo
    import iob_axi_read_responder_pkg::*;
#(
    parameter int WIDTH = 35
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] r_entry [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign w_do_pop  = pop_i  && (r_count != 2'd0);
    assign w_do_push = push_i && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_entry[r_wr_ptr] <= data_i;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign data_o  = r_entry[r_rd_ptr];
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/iob_axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module      : iob_axi_read_responder
// Description : AXI4 read-channel subordinate serving one AR/R burst at a
//               time from a single-port synchronous RAM (1-cycle latency).
//               A two-entry output FIFO keeps full throughput under R
//               back-pressure; issue is throttled by a credit check.
// Ports       : clk_i, reset_i (async, active-high)
//               axi_ar*  - read address channel (id/addr/len/size/burst)
//               axi_r*   - read data channel
//               mem_en_o / mem_addr_o / mem_rdata_i - RAM read port
// Revision    : 1.0 - initial release
// ============================================================================
module iob_axi_read_responder
    import iob_axi_read_responder_pkg::*;
#(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [AXI_ID_W-1:0]   axi_arid_i,
    input  logic [AXI_ADDR_W-1:0] axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
    input  logic [2:0]            axi_arsize_i,
    input  logic [1:0]            axi_arburst_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,
    output logic [AXI_ID_W-1:0]   axi_rid_o,
    output logic [AXI_DATA_W-1:0] axi_rdata_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,
    output logic                  mem_en_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    input  logic [AXI_DATA_W-1:0] mem_rdata_i
);

    localparam int c_nbytes_w = $clog2(AXI_DATA_W / 8);
    localparam int c_map_w    = MEM_ADDR_W + c_nbytes_w;
    localparam int c_entry_w  = AXI_DATA_W + 3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_arready;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [AXI_LEN_W-1:0]  r_beats_left;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  r_bad;
    logic                  r_pipe_valid;
    logic                  r_pipe_err;
    logic                  r_pipe_last;

    logic [1:0]            w_fifo_count;
    logic [c_entry_w-1:0]  w_fifo_in;
    logic [c_entry_w-1:0]  w_fifo_head;
    logic                  w_ar_fire;
    logic                  w_pop;
    logic [2:0]            w_occupancy;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_in_range;
    logic                  w_beat_ok;
    logic                  w_drain_done;
    logic [AXI_ADDR_W-1:0] w_addr_step;

    assign w_ar_fire    = axi_arvalid_i & r_arready;
    assign axi_rvalid_o = (w_fifo_count != 2'd0);
    assign w_pop        = axi_rvalid_o & axi_rready_i;

    // Entries that will occupy the FIFO after this edge; a new issue is only
    // allowed if it leaves room for itself two cycles from now.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_pipe_valid} - {2'b00, w_pop};
    assign w_credit    = (w_occupancy < 3'd2);
    assign w_issue     = (r_state == c_state_issue) && w_credit;

    generate
        if (AXI_ADDR_W > c_map_w) begin : g_range_check
            assign w_in_range = ~|r_addr[AXI_ADDR_W-1:c_map_w];
            assign mem_addr_o = r_addr[c_map_w-1:c_nbytes_w];
        end else begin : g_full_map
            assign w_in_range = 1'b1;
            assign mem_addr_o = MEM_ADDR_W'(r_addr >> c_nbytes_w);
        end
    endgenerate

    assign w_beat_ok   = w_in_range & ~r_bad;
    assign mem_en_o    = w_issue & w_beat_ok;
    assign w_addr_step = AXI_ADDR_W'(1) << r_size;

    // Burst complete once the FIFO empties on this edge and no RAM read
    // is still waiting to be captured.
    assign w_drain_done = ~r_pipe_valid && (w_fifo_count == {1'b0, w_pop});

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_state_idle:  if (w_ar_fire) w_state_next = c_state_issue;
            c_state_issue: if (w_issue && (r_beats_left == '0)) w_state_next = c_state_drain;
            c_state_drain: if (w_drain_done) w_state_next = c_state_idle;
            default:       w_state_next = c_state_idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= c_state_idle;
            r_arready    <= 1'b0;
            r_id         <= '0;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_bad        <= 1'b0;
            r_pipe_valid <= 1'b0;
            r_pipe_err   <= 1'b0;
            r_pipe_last  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_arready <= (w_state_next == c_state_idle);
            if (w_ar_fire) begin
                r_id         <= axi_arid_i;
                r_addr       <= axi_araddr_i;
                r_beats_left <= axi_arlen_i;
                r_size       <= axi_arsize_i;
                r_burst      <= axi_arburst_i;
                r_bad        <= burst_is_bad(axi_arsize_i, axi_arburst_i, c_nbytes_w);
            end else if (w_issue) begin
                r_beats_left <= r_beats_left - 1'b1;
                if (burst_advances(r_burst)) begin
                    r_addr <= r_addr + w_addr_step;
                end
            end
            // Pipe stage lines up with the RAM's registered read data.
            r_pipe_valid <= w_issue;
            r_pipe_err   <= ~w_beat_ok;
            r_pipe_last  <= (r_beats_left == '0);
        end
    end

    assign w_fifo_in = {r_pipe_err ? {AXI_DATA_W{1'b0}} : mem_rdata_i,
                        r_pipe_err ? c_resp_slverr : c_resp_okay,
                        r_pipe_last};

    iob_axi_rd_skid_fifo #(
        .WIDTH (c_entry_w)
    ) u_skid_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (r_pipe_valid),
        .data_i  (w_fifo_in),
        .pop_i   (w_pop),
        .data_o  (w_fifo_head),
        .count_o (w_fifo_count)
    );

    assign axi_arready_o = r_arready;
    assign axi_rid_o     = r_id;
    assign axi_rdata_o   = w_fifo_head[c_entry_w-1:3];
    assign axi_rresp_o   = w_fifo_head[2:1];
    assign axi_rlast_o   = w_fifo_head[0];

endmodule
`default_nettype wire

// File: doc/iob_axi_read_responder.md
# iob_axi_read_responder

AXI4 read-channel subordinate that serves AR/R bursts from a single-port synchronous RAM with one-cycle read latency. It sits at the memory end of the cache back-end read path, as the backing-memory model for cache integration benches and as the on-chip memory port of small SoCs. Full-throughput streaming is preserved under R back-pressure by a two-entry output buffer.

## Interface
- AXI_ID_W, 1, ID width.
- AXI_ADDR_W, 24, byte-address width.
- AXI_DATA_W, 32, data width (power of two, ≥8).
- AXI_LEN_W, 8, burst-length field width.
- MEM_ADDR_W, 16, RAM word-address width; mapped range is [0, 2^(MEM_ADDR_W+NBYTES_W)).
- NBYTES_W (derived), log2(AXI_DATA_W/8).

Ports (reset reset_i, asynchronous, active-high; clock clk_i):
- clk_i  in  1  clock.
- reset_i  in  1  async active-high reset.
- axi_arid_i / araddr_i / arlen_i / arsize_i / arburst_i  in  AXI_ID_W / AXI_ADDR_W / AXI_LEN_W / 3 / 2  request fields; arlock, arcache, arprot, arqos are not ports.
- axi_arvalid_i  in  1;  axi_arready_o  out  1.
- axi_rid_o  out  AXI_ID_W;  axi_rdata_o  out  AXI_DATA_W;  axi_rresp_o  out  2;  axi_rlast_o  out  1;  axi_rvalid_o  out  1.
- axi_rready_i  in  1.
- mem_en_o  out  1  RAM read enable.
- mem_addr_o  out  MEM_ADDR_W  RAM word address.
- mem_rdata_i  in  AXI_DATA_W  RAM data, valid the cycle after mem_en_o.

## Operation
- One burst in flight. States IDLE, ISSUE, DRAIN.
- IDLE: axi_arready_o=1 (registered). On arvalid&arready: latch id, addr, len, size, burst; beats_left=arlen; → ISSUE; arready drops the next cycle.
- Burst check at acceptance: arsize>NBYTES_W or arburst∈{WRAP 2'b10, reserved 2'b11} marks the whole burst bad.
- ISSUE: one beat issued per cycle when credit allows: (fifo_count + inflight − pop) < 2, where pop = rvalid&rready. Issued beat: in-range and burst good → mem_en_o=1, mem_addr_o=addr[MEM_ADDR_W+NBYTES_W-1:NBYTES_W]; otherwise no RAM access, beat flagged error.
- Address update per issued beat: INCR adds 2^size bytes (AXI_ADDR_W-bit wrap-around, no 4 KB check); FIXED holds. Range is checked per beat, so an INCR burst crossing the top yields OKAY beats then SLVERR beats.
- Last issued beat (beats_left==0) → DRAIN. DRAIN: no issue; when FIFO empty and nothing in flight → IDLE.
- Pipe stage (inflight, err, last) aligns with mem_rdata_i; entry written to FIFO the following edge: {rdata = err ? 0 : mem_rdata_i, rresp = err ? 2'b10 : 2'b00, rlast}. rid is constant = latched id.
- R outputs come from FIFO head; rvalid_o=~empty; rvalid held with stable payload until rready (no retraction).
- Narrow transfers return the full RAM word; manager selects lanes.

## Timing
- Reset values: arready 0, rvalid 0, rlast 0, rresp 0, rdata 0, rid 0, mem_en 0, mem_addr 0; state IDLE; FIFO empty; arready 1 on first clock after reset release.
- AR handshake at cycle T → mem_en at T+1 → rvalid first high at T+3.
- rready held high: one beat per cycle, no bubbles; len+1 beats end with rlast.
- rready low: at most two beats buffered; issue stalls; no data lost or duplicated.
- Final beat popped at cycle P → arready high at P+1 (IDLE entry on edge ending P).
- Reset asserted mid-burst: immediate return to reset values; burst abandoned; no R beat after deassertion.

## Structure
- Shared package/header: burst encodings (FIXED 2'b00, INCR 2'b01, WRAP 2'b10), RRESP codes (OKAY 2'b00, SLVERR 2'b10), state encodings.
- Sub-module iob_axi_rd_skid_fifo: 2-entry FIFO of {rdata, rresp, rlast}, count output, async reset.

## Test plan
- Reset, then araddr=0x100, arlen=3, INCR, arsize=NBYTES_W, rready=1, RAM word n = n → rdata 0x40,0x41,0x42,0x43 at T+3..T+6, OKAY, rlast only on 4th, rid echoed.
- Same burst, rready toggled 1,0,0,1,0,1… → identical data order, ≤2 buffered, mem_en never issued without credit, payload stable while stalled.
- FIXED, arlen=2, araddr=0x20 → three beats of word 8, mem_addr_o constant 8.
- INCR burst, arlen=3, starting two words below the top of the map → OKAY, OKAY, SLVERR(0), SLVERR(0); no mem_en for the last two.
- arburst=WRAP or arsize>NBYTES_W, arlen=1 → two SLVERR beats, rdata 0, mem_en never high.
- Back-to-back ARs with arvalid held → second accepted the cycle after first rlast pop; reset pulse mid-burst → rvalid 0, arready 0 during reset, arready 1 after release, no stale beats.
